// File: rtl/alu_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the ALU sharing arbiter: FSM states, ALU op codes and default widths.
package alu_pkg;

    localparam int unsigned DW_DEFAULT   = 8;
    localparam int unsigned OPW_DEFAULT  = 4;
    localparam int unsigned CNTW_DEFAULT = 16;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } arb_state_e;

    // ALU_cont encodings; the arbiter passes them through untouched.
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTR = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_XOR  = 4'b1101;

endpackage

// File: rtl/rr_arb2.sv
`timescale 1ns/1ps
// Two-way round-robin picker: a lone request wins outright, a tie goes to the requester that
// was not granted last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
`timescale 1ns/1ps
// Shares one external combinational ALU between two valid/ready requesters, one op in flight,
// with a registered, id-tagged response channel and per-requester completion counters.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned DW   = DW_DEFAULT,
    parameter int unsigned OPW  = OPW_DEFAULT,
    parameter int unsigned CNTW = CNTW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            r0_valid,
    output logic            r0_ready,
    input  logic [OPW-1:0]  r0_op,
    input  logic [DW-1:0]   r0_a,
    input  logic [DW-1:0]   r0_b,
    input  logic            r1_valid,
    output logic            r1_ready,
    input  logic [OPW-1:0]  r1_op,
    input  logic [DW-1:0]   r1_a,
    input  logic [DW-1:0]   r1_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [DW-1:0]   rsp_x,
    output logic            rsp_cout,
    output logic            rsp_zero,
    output logic            rsp_ov,
    output logic [DW-1:0]   alu_a,
    output logic [DW-1:0]   alu_b,
    output logic [OPW-1:0]  alu_op,
    output logic            alu_cin,
    input  logic [DW-1:0]   alu_x,
    input  logic            alu_cout,
    input  logic            alu_zero,
    input  logic            alu_ov,
    output logic [CNTW-1:0] cnt0,
    output logic [CNTW-1:0] cnt1
);

    arb_state_e      state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic            gnt_id_q, gnt_id_d;
    logic [DW-1:0]   alu_a_q, alu_a_d;
    logic [DW-1:0]   alu_b_q, alu_b_d;
    logic [OPW-1:0]  alu_op_q, alu_op_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_id_q, rsp_id_d;
    logic [DW-1:0]   rsp_x_q, rsp_x_d;
    logic            rsp_cout_q, rsp_cout_d;
    logic            rsp_zero_q, rsp_zero_d;
    logic            rsp_ov_q, rsp_ov_d;
    logic [CNTW-1:0] cnt0_q, cnt0_d;
    logic [CNTW-1:0] cnt1_q, cnt1_d;

    logic [1:0] arb_req;
    logic [1:0] arb_gnt;

    // Requests are masked during reset so no ready is offered while the block is being cleared.
    assign arb_req = {r1_valid, r0_valid} & {2{~rst}};

    rr_arb2 u_rr_arb2 (
        .req  (arb_req),
        .last (last_grant_q),
        .gnt  (arb_gnt)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_id_d     = gnt_id_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_x_d      = rsp_x_q;
        rsp_cout_d   = rsp_cout_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_ov_d     = rsp_ov_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        r0_ready     = 1'b0;
        r1_ready     = 1'b0;

        unique case (state_q)
            StIdle: begin
                // The grant doubles as ready, so a grant is always a completed handshake.
                r0_ready = arb_gnt[0];
                r1_ready = arb_gnt[1];
                if (|arb_gnt) begin
                    alu_op_d     = arb_gnt[1] ? r1_op : r0_op;
                    alu_a_d      = arb_gnt[1] ? r1_a  : r0_a;
                    alu_b_d      = arb_gnt[1] ? r1_b  : r0_b;
                    gnt_id_d     = arb_gnt[1];
                    last_grant_d = arb_gnt[1];
                    state_d      = StExec;
                end
            end
            StExec: begin
                rsp_x_d     = alu_x;
                rsp_cout_d  = alu_cout;
                rsp_zero_d  = alu_zero;
                rsp_ov_d    = alu_ov;
                rsp_id_d    = gnt_id_q;
                rsp_valid_d = 1'b1;
                state_d     = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (gnt_id_q) begin
                        cnt1_d = cnt1_q + 1'b1;
                    end else begin
                        cnt0_d = cnt0_q + 1'b1;
                    end
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            gnt_id_q     <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_x_q      <= '0;
            rsp_cout_q   <= 1'b0;
            rsp_zero_q   <= 1'b0;
            rsp_ov_q     <= 1'b0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_id_q     <= gnt_id_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_x_q      <= rsp_x_d;
            rsp_cout_q   <= rsp_cout_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_ov_q     <= rsp_ov_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_x     = rsp_x_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_ov    = rsp_ov_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign alu_cin   = 1'b0;
    assign cnt0      = cnt0_q;
    assign cnt1      = cnt1_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
`timescale 1ns/1ps
// Bench for alu_share_arbiter: a stand-in 8-bit ALU drives the alu_* inputs, and a
// transaction-level model predicts grants, response timing, payloads and counters.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    localparam int unsigned DW   = 8;
    localparam int unsigned OPW  = 4;
    localparam int unsigned CNTW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            r0_valid = 1'b0, r1_valid = 1'b0;
    logic            r0_ready, r1_ready;
    logic [OPW-1:0]  r0_op = '0, r1_op = '0;
    logic [DW-1:0]   r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0;
    logic            rsp_valid, rsp_id, rsp_cout, rsp_zero, rsp_ov;
    logic            rsp_ready = 1'b0;
    logic [DW-1:0]   rsp_x;
    logic [DW-1:0]   alu_a, alu_b, alu_x;
    logic [OPW-1:0]  alu_op;
    logic            alu_cin, alu_cout, alu_zero, alu_ov;
    logic [CNTW-1:0] cnt0, cnt1;

    int n_cmp = 0;
    int n_err = 0;

    // Scoreboard state: one outstanding op at most.
    bit          busy = 1'b0;
    bit          last = 1'b1;
    bit          exp_id;
    logic [10:0] exp_res;
    int          acc_cyc = 0;
    int          cyc = 0;
    int          exp_cnt [2] = '{0, 0};
    logic [7:0]  last_rsp_x = '0;

    always #0.5 clk = ~clk;

    alu_share_arbiter #(.DW(DW), .OPW(OPW), .CNTW(CNTW)) dut (
        .clk       (clk),
        .rst       (rst),
        .r0_valid  (r0_valid),
        .r0_ready  (r0_ready),
        .r0_op     (r0_op),
        .r0_a      (r0_a),
        .r0_b      (r0_b),
        .r1_valid  (r1_valid),
        .r1_ready  (r1_ready),
        .r1_op     (r1_op),
        .r1_a      (r1_a),
        .r1_b      (r1_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_x     (rsp_x),
        .rsp_cout  (rsp_cout),
        .rsp_zero  (rsp_zero),
        .rsp_ov    (rsp_ov),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_cin   (alu_cin),
        .alu_x     (alu_x),
        .alu_cout  (alu_cout),
        .alu_zero  (alu_zero),
        .alu_ov    (alu_ov),
        .cnt0      (cnt0),
        .cnt1      (cnt1)
    );

    // Returns {cout, zero, ov, x}.
    function automatic logic [10:0] alu_eval(input logic [3:0] op, input logic [7:0] a,
                                             input logic [7:0] b);
        logic [8:0] s;
        logic [7:0] x;
        logic       c, v;
        s = '0;
        x = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            OP_AND:  x = a & b;
            OP_OR:   x = a | b;
            OP_NOR:  x = ~(a | b);
            OP_XOR:  x = a ^ b;
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                x = s[7:0];
                c = s[8];
                v = (a[7] == b[7]) && (x[7] != a[7]);
            end
            OP_SUB: begin
                s = {1'b0, a} + {1'b0, ~b} + 9'd1;
                x = s[7:0];
                c = s[8];
                v = (a[7] != b[7]) && (x[7] != a[7]);
            end
            OP_SLT:  x = {7'd0, $signed(a) < $signed(b)};
            OP_SLTR: x = {7'd0, $signed(b) < $signed(a)};
            default: x = '0;
        endcase
        return {c, x == 8'd0, v, x};
    endfunction

    always_comb {alu_cout, alu_zero, alu_ov, alu_x} = alu_eval(alu_op, alu_a, alu_b);

    function automatic logic [3:0] rand_op();
        case ($urandom_range(7))
            0: return OP_AND;
            1: return OP_OR;
            2: return OP_ADD;
            3: return OP_SUB;
            4: return OP_SLT;
            5: return OP_SLTR;
            6: return OP_NOR;
            default: return OP_XOR;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // One clock: drive inputs at the falling edge, check against the model, then advance it
    // by whatever handshakes the coming rising edge will complete.
    task automatic cycle(input bit v0, input logic [3:0] op0, input logic [7:0] a0,
                         input logic [7:0] b0, input bit v1, input logic [3:0] op1,
                         input logic [7:0] a1, input logic [7:0] b1, input bit rr, input bit rs);
        bit e0, e1, erv;
        @(negedge clk);
        r0_valid = v0; r0_op = op0; r0_a = a0; r0_b = b0;
        r1_valid = v1; r1_op = op1; r1_a = a1; r1_b = b1;
        rsp_ready = rr;
        rst = rs;
        #0.1;
        e0  = !rs && !busy && v0 && (!v1 || last);
        e1  = !rs && !busy && v1 && (!v0 || !last);
        erv = busy && (cyc - acc_cyc >= 2);
        check_eq("r0_ready", r0_ready, e0);
        check_eq("r1_ready", r1_ready, e1);
        check_eq("rsp_valid", rsp_valid, erv);
        if (erv) begin
            check_eq("rsp_id", rsp_id, exp_id);
            check_eq("rsp_x", rsp_x, exp_res[7:0]);
            check_eq("rsp_cout", rsp_cout, exp_res[10]);
            check_eq("rsp_zero", rsp_zero, exp_res[9]);
            check_eq("rsp_ov", rsp_ov, exp_res[8]);
        end
        check_eq("cnt0", cnt0, exp_cnt[0]);
        check_eq("cnt1", cnt1, exp_cnt[1]);
        if (rs) begin
            busy = 1'b0;
            last = 1'b1;
            exp_cnt = '{0, 0};
        end else if (erv && rr) begin
            busy = 1'b0;
            exp_cnt[exp_id] = (exp_cnt[exp_id] + 1) % (1 << CNTW);
            last_rsp_x = rsp_x;
        end else if (e0 || e1) begin
            busy    = 1'b1;
            acc_cyc = cyc;
            exp_id  = e1;
            last    = e1;
            exp_res = e1 ? alu_eval(op1, a1, b1) : alu_eval(op0, a0, b0);
        end
        cyc++;
    endtask

    task automatic idle(input int n, input bit rr);
        for (int i = 0; i < n; i++) cycle(0, '0, '0, '0, 0, '0, '0, '0, rr, 0);
    endtask

    task automatic req0(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        cycle(1, op, a, b, 0, '0, '0, '0, 1, 0);
    endtask

    task automatic req1(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        cycle(0, '0, '0, '0, 1, op, a, b, 1, 0);
    endtask

    initial begin
        // Reset state, with a request pending to show no ready is offered during reset.
        r0_valid = 1'b1;
        repeat (3) @(negedge clk);
        #0.1;
        check_eq("rst_r0_ready", r0_ready, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_rsp_id", rsp_id, 0);
        check_eq("rst_rsp_x", rsp_x, 0);
        check_eq("rst_flags", {rsp_cout, rsp_zero, rsp_ov}, 0);
        check_eq("rst_alu_a", alu_a, 0);
        check_eq("rst_alu_b", alu_b, 0);
        check_eq("rst_alu_op", alu_op, 0);
        check_eq("rst_alu_cin", alu_cin, 0);
        check_eq("rst_cnt0", cnt0, 0);
        check_eq("rst_cnt1", cnt1, 0);

        // R0 alone: 13 + 7.
        req0(OP_ADD, 8'd13, 8'd7);
        idle(3, 1);
        check_eq("t1_x", last_rsp_x, 20);
        check_eq("t1_cnt0", cnt0, 1);

        // Both valid every cycle: grants alternate.
        for (int i = 0; i < 24; i++) begin
            cycle(1, rand_op(), 8'($urandom), 8'($urandom),
                  1, rand_op(), 8'($urandom), 8'($urandom), 1, 0);
        end
        idle(3, 1);

        // Response stall with both requesters pushing.
        cycle(1, OP_SUB, 8'd5, 8'd9, 1, OP_XOR, 8'hA5, 8'h5A, 0, 0);
        for (int i = 0; i < 6; i++) cycle(1, OP_AND, 8'hF0, 8'h3C, 1, OP_OR, 8'h01, 8'h02, 0, 0);
        cycle(1, OP_AND, 8'hF0, 8'h3C, 1, OP_OR, 8'h01, 8'h02, 1, 0);
        idle(4, 1);

        // Signed compares: -3 < 5.
        req0(OP_SLT, 8'hFD, 8'd5);
        idle(3, 1);
        check_eq("t4_slt", last_rsp_x[0], 1);
        req0(OP_SLTR, 8'hFD, 8'd5);
        idle(3, 1);
        check_eq("t4_sltr", last_rsp_x[0], 0);

        // Reset while the op is in its execute cycle.
        req1(OP_ADD, 8'd100, 8'd100);
        cycle(0, '0, '0, '0, 0, '0, '0, '0, 1, 1);
        idle(4, 1);
        check_eq("t5_cnt0", cnt0, 0);
        check_eq("t5_cnt1", cnt1, 0);
        cycle(1, OP_ADD, 8'd1, 8'd2, 1, OP_ADD, 8'd3, 8'd4, 1, 0);
        idle(3, 1);
        check_eq("t5_first_x", last_rsp_x, 3);

        // Counter wrap on R1.
        cycle(0, '0, '0, '0, 0, '0, '0, '0, 0, 1);
        for (int i = 0; i < 15; i++) begin
            req1(rand_op(), 8'($urandom), 8'($urandom));
            idle(2, 1);
        end
        idle(1, 1);
        check_eq("t6_cnt1_max", cnt1, 15);
        req1(OP_OR, 8'h0F, 8'hF0);
        idle(3, 1);
        check_eq("t6_cnt1_wrap", cnt1, 0);
        check_eq("t6_cnt0", cnt0, 0);

        // Random traffic, including dropped requests, stalls and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(2) != 0, rand_op(), 8'($urandom), 8'($urandom),
                  $urandom_range(2) != 0, rand_op(), 8'($urandom), 8'($urandom),
                  $urandom_range(3) != 0, $urandom_range(199) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
